// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: evaluates RV32I conditional branches, produces the
// redirect PC and mispredict flag, and trains a 2-bit saturating-counter BHT.
`default_nettype none

module branch_resolve_unit #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [2:0]       FUNCT3,
  input  logic [XLEN-1:0]  A,
  input  logic [XLEN-1:0]  B,
  input  logic [XLEN-1:0]  PC,
  input  logic [XLEN-1:0]  IMM,
  input  logic             PRED_TAKEN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             TAKEN,
  output logic [XLEN-1:0]  TARGET,
  output logic [XLEN-1:0]  REDIRECT_PC,
  output logic             MISPREDICT,
  output logic             ILLEGAL,
  input  logic [XLEN-1:0]  LOOKUP_PC,
  output logic             LOOKUP_PRED,
  output logic [CNT_W-1:0] MISPRED_CNT
);

  localparam int IDXW = $clog2(BHT_DEPTH);
  localparam logic [1:0] CNT_RESET = 2'b01;

  // Comparison and direction decode
  logic            w_eq;
  logic            w_lts;
  logic            w_ltu;
  logic            w_taken;
  logic            w_illegal;
  logic            w_mispred;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_seq_pc;
  logic [XLEN-1:0] w_redirect;
  logic            w_accept;
  logic [IDXW-1:0] w_upd_idx;
  logic [IDXW-1:0] w_lkp_idx;

  assign w_eq  = (A == B);
  assign w_lts = ($signed(A) < $signed(B));
  assign w_ltu = (A < B);

  always_comb begin
    w_taken   = 1'b0;
    w_illegal = 1'b0;
    case (FUNCT3)
      3'b000:  w_taken = w_eq;
      3'b001:  w_taken = !w_eq;
      3'b100:  w_taken = w_lts;
      3'b101:  w_taken = !w_lts;
      3'b110:  w_taken = w_ltu;
      3'b111:  w_taken = !w_ltu;
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_mispred  = !w_illegal && (w_taken != PRED_TAKEN);
  assign w_target   = PC + IMM;
  assign w_seq_pc   = PC + {{(XLEN-3){1'b0}}, 3'd4};
  assign w_redirect = w_taken ? w_target : w_seq_pc;

  // Handshake and output register
  logic            valid_q;
  logic            taken_q;
  logic [XLEN-1:0] target_q;
  logic [XLEN-1:0] redirect_q;
  logic            mispred_q;
  logic            illegal_q;

  assign IN_READY = !FLUSH && (!valid_q || OUT_READY);
  assign w_accept = IN_VALID && IN_READY;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q    <= 1'b0;
      taken_q    <= 1'b0;
      target_q   <= '0;
      redirect_q <= '0;
      mispred_q  <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (FLUSH) begin
      valid_q <= 1'b0;
    end else if (w_accept) begin
      valid_q    <= 1'b1;
      taken_q    <= w_taken;
      target_q   <= w_target;
      redirect_q <= w_redirect;
      mispred_q  <= w_mispred;
      illegal_q  <= w_illegal;
    end else if (OUT_READY) begin
      valid_q <= 1'b0;
    end
  end

  assign OUT_VALID   = valid_q;
  assign TAKEN       = taken_q;
  assign TARGET      = target_q;
  assign REDIRECT_PC = redirect_q;
  assign MISPREDICT  = mispred_q;
  assign ILLEGAL     = illegal_q;

  // Saturating mispredict counter
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (w_accept && w_mispred && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign MISPRED_CNT = cnt_q;

  // Branch history table; lookup reads the registered state so a same-index
  // update in the same cycle is only visible after the edge.
  logic [1:0] bht_q [BHT_DEPTH];
  logic [1:0] bht_d [BHT_DEPTH];

  assign w_upd_idx = PC[IDXW+1:2];
  assign w_lkp_idx = LOOKUP_PC[IDXW+1:2];

  always_comb begin
    for (int i = 0; i < BHT_DEPTH; i++) begin
      bht_d[i] = bht_q[i];
    end
    if (w_accept && !w_illegal) begin
      if (w_taken && (bht_q[w_upd_idx] != 2'b11)) begin
        bht_d[w_upd_idx] = bht_q[w_upd_idx] + 2'b01;
      end else if (!w_taken && (bht_q[w_upd_idx] != 2'b00)) begin
        bht_d[w_upd_idx] = bht_q[w_upd_idx] - 2'b01;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= CNT_RESET;
      end
    end else begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= bht_d[i];
      end
    end
  end

  assign LOOKUP_PRED = bht_q[w_lkp_idx][1];

  logic unused_lookup_bits;
  assign unused_lookup_bits = ^{LOOKUP_PC[XLEN-1:IDXW+2], LOOKUP_PC[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus a
// randomized phase, all compared against a behavioural model.
`default_nettype none

module tb_branch_resolve_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 16;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b1;
  logic             pred = 1'b0;
  logic [2:0]       f3 = 3'b000;
  logic [XLEN-1:0]  a = '0, b = '0, pc = '0, imm = '0, lpc = '0;
  logic             in_ready, out_valid, taken, mis, ill, lpred;
  logic [XLEN-1:0]  target, redirect;
  logic [CNT_W-1:0] cnt;

  branch_resolve_unit #(.XLEN(XLEN), .BHT_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(clk), .RST(rst), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(in_ready),
    .FUNCT3(f3), .A(a), .B(b), .PC(pc), .IMM(imm), .PRED_TAKEN(pred),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .TAKEN(taken), .TARGET(target),
    .REDIRECT_PC(redirect), .MISPREDICT(mis), .ILLEGAL(ill),
    .LOOKUP_PC(lpc), .LOOKUP_PRED(lpred), .MISPRED_CNT(cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit              m_valid, m_taken, m_mis, m_ill;
  logic [XLEN-1:0] m_target, m_redir;
  int              m_cnt;
  int              m_bht [DEPTH];
  int              n_checks = 0;
  int              n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_taken = 0; m_mis = 0; m_ill = 0;
    m_target = '0; m_redir = '0; m_cnt = 0;
    for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
  endtask

  function automatic bit exp_taken(input logic [2:0] f, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
    case (f)
      3'd0: return x == y;
      3'd1: return x != y;
      3'd4: return int'(x) < int'(y);
      3'd5: return int'(x) >= int'(y);
      3'd6: return x < y;
      3'd7: return x >= y;
      default: return 1'b0;
    endcase
  endfunction

  // One clock: check visible state before the edge, then advance the model.
  task automatic step(output bit acc);
    bit rdy, t;
    int idx;
    @(negedge clk);
    rdy = !flush && (!m_valid || out_ready);
    check_eq("in_ready", in_ready, rdy);
    check_eq("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check_eq("taken", taken, m_taken);
      check_eq("target", target, m_target);
      check_eq("redirect_pc", redirect, m_redir);
      check_eq("mispredict", mis, m_mis);
      check_eq("illegal", ill, m_ill);
    end
    check_eq("mispred_cnt", cnt, m_cnt);
    check_eq("lookup_pred", lpred, m_bht[lpc[5:2]] >= 2);
    acc = in_valid && rdy;
    @(posedge clk);
    #1;
    if (flush) begin
      m_valid = 0;
    end else if (acc) begin
      t        = exp_taken(f3, a, b);
      m_valid  = 1;
      m_ill    = (f3 == 3'd2) || (f3 == 3'd3);
      m_taken  = t;
      m_target = pc + imm;
      m_redir  = t ? pc + imm : pc + 4;
      m_mis    = !m_ill && (t != pred);
      if (!m_ill) begin
        idx = int'(pc[5:2]);
        if (t && m_bht[idx] < 3) m_bht[idx]++;
        if (!t && m_bht[idx] > 0) m_bht[idx]--;
      end
      if (m_mis && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end else if (out_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic send(input logic [2:0] f, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                      input logic [XLEN-1:0] p, input logic [XLEN-1:0] im, input bit pr);
    bit acc;
    f3 = f; a = x; b = y; pc = p; imm = im; pred = pr; in_valid = 1;
    acc = 0;
    for (int k = 0; k < 20 && !acc; k++) step(acc);
    check_eq("send_accepted", acc, 1);
    in_valid = 0;
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = 0;
    for (int k = 0; k < n; k++) step(acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int saved;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_taken", taken, 0);
    check_eq("rst_target", target, 0);
    check_eq("rst_redirect", redirect, 0);
    check_eq("rst_mispredict", mis, 0);
    check_eq("rst_illegal", ill, 0);
    check_eq("rst_cnt", cnt, 0);
    check_eq("rst_lookup", lpred, 0);
    rst = 0;
    idle(1);

    // Signed vs unsigned compare of the same operands
    send(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 0);
    check_eq("blt_taken", taken, 1);
    check_eq("blt_target", target, 32'h120);
    check_eq("blt_redirect", redirect, 32'h120);
    check_eq("blt_mispredict", mis, 1);
    check_eq("blt_cnt", cnt, 1);
    send(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 0);
    check_eq("bltu_taken", taken, 0);
    check_eq("bltu_redirect", redirect, 32'h104);
    idle(1);

    // Decode table over equal, less-than and illegal encodings
    for (int f = 0; f < 8; f++) send(3'(f), 32'd5, 32'd5, 32'h40, 32'h10, 1);
    for (int f = 0; f < 8; f++) send(3'(f), 32'd3, 32'd7, 32'h44, 32'h10, 0);
    for (int f = 0; f < 8; f++) send(3'(f), 32'd7, 32'd3, 32'h48, 32'hFFFF_FFF0, 1);
    send(3'b010, 32'd1, 32'd1, 32'h8, 32'h4, 1);
    check_eq("illegal_flag", ill, 1);
    check_eq("illegal_taken", taken, 0);
    check_eq("illegal_mispredict", mis, 0);
    idle(1);

    // Backpressure: first result held while three more ops wait
    out_ready = 0;
    send(3'b000, 32'd1, 32'd1, 32'h10, 32'h8, 0);
    f3 = 3'b001; a = 32'd1; b = 32'd2; pc = 32'h14; imm = 32'h8; pred = 0; in_valid = 1;
    for (int k = 0; k < 3; k++) begin
      step(acc);
      check_eq("stall_no_accept", acc, 0);
    end
    out_ready = 1;
    send(3'b001, 32'd1, 32'd2, 32'h14, 32'h8, 0);
    send(3'b101, 32'd9, 32'd2, 32'h18, 32'h8, 1);
    send(3'b111, 32'd0, 32'd2, 32'h1C, 32'h8, 1);
    idle(2);

    // BHT training on index 2 with lookup on the same entry
    lpc = 32'h8;
    for (int k = 0; k < 3; k++) send(3'b000, 32'd4, 32'd4, 32'h8, 32'h40, 1);
    check_eq("bht_sat_taken", lpred, 1);
    for (int k = 0; k < 4; k++) send(3'b000, 32'd4, 32'd5, 32'h8, 32'h40, 0);
    check_eq("bht_sat_not_taken", lpred, 0);
    idle(1);

    // Flush drops the incoming op and invalidates the held result
    out_ready = 0;
    send(3'b000, 32'd1, 32'd1, 32'h20, 32'h4, 0);
    saved = int'(cnt);
    f3 = 3'b000; a = 32'd2; b = 32'd2; pc = 32'h8; imm = 32'h4; pred = 0;
    in_valid = 1; flush = 1;
    step(acc);
    flush = 0; in_valid = 0; out_ready = 1;
    check_eq("flush_out_valid", out_valid, 0);
    check_eq("flush_cnt", cnt, saved);
    idle(2);

    // Address wrap-around
    send(3'b000, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'h8, 1);
    check_eq("wrap_target", target, 32'h4);
    check_eq("wrap_redirect", redirect, 32'h0);
    idle(1);

    // Asynchronous reset in the middle of a stall
    out_ready = 0;
    send(3'b000, 32'd1, 32'd1, 32'h4, 32'h4, 0);
    idle(1);
    #2 rst = 1;
    #1;
    check_eq("arst_out_valid", out_valid, 0);
    check_eq("arst_cnt", cnt, 0);
    for (int i = 0; i < DEPTH; i++) begin
      lpc = 32'(i << 2);
      #1;
      check_eq("arst_bht", lpred, 0);
    end
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    out_ready = 1;
    lpc = 32'h4;
    send(3'b000, 32'd1, 32'd1, 32'h4, 32'h4, 1);
    idle(1);

    // Randomized traffic
    for (int k = 0; k < 500; k++) begin
      f3        = 3'($urandom_range(0, 7));
      a         = $urandom;
      b         = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b = a + 32'($urandom_range(0, 2)) - 32'd1;
      pc        = {$urandom} & 32'hFFFF_FFFC;
      imm       = 32'($signed($urandom_range(0, 8191)) - 4096);
      pred      = 1'($urandom_range(0, 1));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      lpc       = ($urandom_range(0, 1) == 0) ? pc : $urandom;
      step(acc);
    end
    flush = 0; in_valid = 0; out_ready = 1;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised branch resolution stage for the RISC-V MCU pipeline.
- Compares rs1/rs2 for all six RV32I conditional branches, computes the branch target and the correct-path redirect PC, and flags mispredicts against the front-end prediction.
- Holds a direct-mapped table of 2-bit saturating counters (BHT) that the fetch stage reads and this block trains.
- Output is registered with a valid/ready handshake. Sits between decode/execute and the PC-select logic.

Parameters:
- XLEN, 32, operand/PC width (>=8).
- BHT_DEPTH, 16, number of BHT entries; power of 2, >=2; index IDXW = log2(BHT_DEPTH).
- CNT_W, 16, width of the saturating mispredict performance counter.

Ports:
- CLK  in  1  clock; all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- FLUSH  in  1  synchronous pipeline flush.
- IN_VALID  in  1  branch op presented.
- IN_READY  out  1  op accepted when IN_VALID&&IN_READY.
- FUNCT3  in  3  branch funct3.
- A  in  XLEN  rs1 value.
- B  in  XLEN  rs2 value.
- PC  in  XLEN  branch PC.
- IMM  in  XLEN  sign-extended B-type immediate.
- PRED_TAKEN  in  1  front-end prediction for this op.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer ready.
- TAKEN  out  1  resolved direction.
- TARGET  out  XLEN  PC+IMM.
- REDIRECT_PC  out  XLEN  TAKEN ? TARGET : PC+4.
- MISPREDICT  out  1  TAKEN != PRED_TAKEN (0 when ILLEGAL).
- ILLEGAL  out  1  FUNCT3 is 010 or 011.
- LOOKUP_PC  in  XLEN  fetch PC for prediction.
- LOOKUP_PRED  out  1  combinational prediction (counter MSB).
- MISPRED_CNT  out  CNT_W  mispredict count.

Behaviour:
- Reset (async, RST=1):
  - OUT_VALID=0; TAKEN, TARGET, REDIRECT_PC, MISPREDICT, ILLEGAL all 0.
  - MISPRED_CNT=0.
  - Every BHT entry = 2'b01 (weakly not-taken).
  - Reset mid-transfer discards the held result.
- Comparison:
  - EQ = A==B.
  - LTS = signed A<B.
  - LTU = unsigned A<B.
- Direction decode:
  - 000 BEQ=EQ; 001 BNE=!EQ; 100 BLT=LTS; 101 BGE=!LTS; 110 BLTU=LTU; 111 BGEU=!LTU.
  - 010/011: TAKEN=0, ILLEGAL=1, MISPREDICT=0.
- Arithmetic:
  - TARGET = PC+IMM modulo 2^XLEN; PC+4 also wraps modulo 2^XLEN.
  - No overflow flags.
- Handshake:
  - Single output register.
  - IN_READY = !FLUSH && (!OUT_VALID || OUT_READY).
  - Latency 1 cycle: op accepted at edge N appears with OUT_VALID=1 after edge N.
  - Back-to-back throughput 1/cycle while OUT_READY=1.
  - While OUT_VALID && !OUT_READY, all outputs stay stable.
  - OUT_VALID clears after a transfer edge with no new accept.
- FLUSH:
  - On the edge with FLUSH=1, OUT_VALID→0 and any IN_VALID that cycle is dropped.
  - BHT and MISPRED_CNT are not updated by a dropped op.
  - The result register is simply invalidated.
- BHT index:
  - idx = PC[IDXW+1:2]; LOOKUP uses LOOKUP_PC[IDXW+1:2].
- BHT update (at accept edge, legal FUNCT3 only):
  - Taken: counter += 1, saturating at 11.
  - Not taken: counter -= 1, saturating at 00.
  - LOOKUP_PRED = entry[idx][1], purely combinational.
  - Same-cycle lookup and update of the same index returns the pre-update value.
- MISPRED_CNT:
  - Increments at accept edge when the computed mispredict = 1, saturating at all-ones.
  - Cleared only by RST.

Test Plan:
- BLT A=0xFFFFFFFF, B=1, PC=0x100, IMM=0x20, PRED_TAKEN=0 → next cycle TAKEN=1, TARGET=0x120, REDIRECT_PC=0x120, MISPREDICT=1, MISPRED_CNT=1. Same operands with BLTU → TAKEN=0, REDIRECT_PC=0x104.
- All six funct3 with A=B=5, then A=3/B=7 → TAKEN matches the decode table; FUNCT3=010 → ILLEGAL=1, TAKEN=0, BHT entry unchanged.
- Stream 4 ops with OUT_READY=0 after the first → IN_READY=0, first result held stable 3 cycles; release OUT_READY → remaining ops emerge one per cycle in order.
- PC=0x8 (idx 2): 3 taken BEQ → entry 01→10→11→11, LOOKUP_PRED(0x8)=1; 4 not-taken → 11→10→01→00→00, LOOKUP_PRED=0. LOOKUP same idx during update sees old value.
- FLUSH asserted with OUT_VALID=1 and IN_VALID=1 → OUT_VALID=0 next cycle, IN_READY=0 during FLUSH, no BHT/counter change.
- PC=0xFFFFFFFC, IMM=8 → TARGET=0x4; not-taken REDIRECT_PC=0x0. RST asserted asynchronously mid-stall → OUT_VALID, MISPRED_CNT, and all BHT entries return to reset values immediately.
